axilite_peripheral_regfile: RTL
===============================

Name: axilite_peripheral_regfile

Overview:
- AXI-Lite slave register bank on the downstream side of axilite_noc_bridge.
- Consumes the bridge's m_axi_* master channels and terminates write, read and write-response traffic, so NoC loads and stores to the peripheral complete end-to-end.
- Provides NUM_REGS full-width registers with byte-strobe writes, address decode errors and per-channel handshake state machines.

Parameters:
- AXILITE_ADDR_WIDTH, 64, address width of AW/AR channels.
- AXILITE_DATA_WIDTH, 512, data width; must be a power of two and at least 32.
- NUM_REGS, 8, number of registers; must be a power of two and at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_axi_awaddr  in  AXILITE_ADDR_WIDTH  write address
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_wdata  in  AXILITE_DATA_WIDTH  write data
- s_axi_wstrb  in  AXILITE_DATA_WIDTH/8  byte enables
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_araddr  in  AXILITE_ADDR_WIDTH  read address
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_rdata  out  AXILITE_DATA_WIDTH  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high on rst.
  - Reset values: all registers 0, awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - Reset asserted mid-transaction discards all latched AW/W/AR state and any pending B/R response, with no write commit.
- Address decode:
  - OFS = log2(AXILITE_DATA_WIDTH/8), IW = log2(NUM_REGS).
  - Register index = addr[OFS+IW-1:OFS]. Bits below OFS are ignored.
  - If any of addr[AXILITE_ADDR_WIDTH-1:OFS+IW] is nonzero, the access is a decode error: DECERR, 2'b11.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: AW and W are accepted independently and in either order. awready drops the cycle after an AW handshake; wready drops the cycle after a W handshake.
  - When both have been captured (same cycle or different cycles), the write commits at that clock edge and the FSM enters W_RESP.
  - Commit: for each byte i with wstrb[i]=1, reg[idx][8i+7:8i] <= wdata byte. Decode-error writes modify nothing.
  - W_RESP: bvalid=1 with bresp=OKAY (2'b00) or DECERR; awready=wready=0. Responses are never stalled.
  - bvalid and bresp stay stable until bready. On the B handshake: bvalid=0, awready=wready=1, FSM returns to W_IDLE.
  - Back-to-back throughput is one write per 2 cycles with bready tied high.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On an AR handshake, rdata <= reg[idx] (pre-edge value) or 0 on DECERR; rresp is set; next state R_DATA.
  - R_DATA: rvalid=1, arready=0. rdata and rresp stay stable until rready.
  - On the R handshake: rvalid=0, arready=1, FSM returns to R_IDLE. Read latency is 1 cycle from the AR handshake to rvalid.
- Read/write interaction:
  - Read and write FSMs are fully independent.
  - A read captured on the same edge as a write commit to the same register returns the old value.
  - A read captured on any later edge returns the new value.

Test Plan:
- Reset, then AW=0x40, W=0xA5A5…(full width), wstrb=all-1 in the same cycle -> bvalid 1 cycle later with bresp=0. Then AR=0x40 -> rvalid 1 cycle after the AR handshake with rdata=0xA5A5…, rresp=0.
- W handshake 3 cycles before AW (addr 0x80) -> wready low while waiting, commit on the AW edge, bvalid next cycle. bready held low 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout.
- Write 0xFF…FF to reg 2 (addr 0x80), then wstrb=0x1 with data 0x00 -> reading reg 2 gives 0xFF…FF00.
- Write to addr with a bit above OFS+IW set (e.g. 0x1000 for defaults) -> bresp=2'b11, no register changes. Read of the same addr -> rresp=2'b11, rdata=0.
- AR to reg 1 on the same edge as a write commit to reg 1 (old 0x0, new 0x5) -> rdata=0x0. A subsequent read returns 0x5.
- Assert rst while in W_RESP and R_DATA -> next cycle bvalid=rvalid=0, all readies 1, registers 0.

Source files
------------

// File: rtl/axilite_peripheral_regfile_if.sv
// AXI-Lite bus bundle between an upstream master (e.g. axilite_noc_bridge) and a
// slave register bank.
//
// Signals:
//   s_axi_aw*  write address channel  (addr, valid / ready)
//   s_axi_w*   write data channel     (data, strobe, valid / ready)
//   s_axi_b*   write response channel (resp, valid / ready)
//   s_axi_ar*  read address channel   (addr, valid / ready)
//   s_axi_r*   read data channel      (data, resp, valid / ready)
// Modports: master drives requests, slave drives readies and responses.
interface axilite_peripheral_regfile_if #(
   parameter int AXILITE_ADDR_WIDTH = 64,
   parameter int AXILITE_DATA_WIDTH = 512
);
   logic [AXILITE_ADDR_WIDTH-1:0]   s_axi_awaddr;
   logic                            s_axi_awvalid;
   logic                            s_axi_awready;
   logic [AXILITE_DATA_WIDTH-1:0]   s_axi_wdata;
   logic [AXILITE_DATA_WIDTH/8-1:0] s_axi_wstrb;
   logic                            s_axi_wvalid;
   logic                            s_axi_wready;
   logic [1:0]                      s_axi_bresp;
   logic                            s_axi_bvalid;
   logic                            s_axi_bready;
   logic [AXILITE_ADDR_WIDTH-1:0]   s_axi_araddr;
   logic                            s_axi_arvalid;
   logic                            s_axi_arready;
   logic [AXILITE_DATA_WIDTH-1:0]   s_axi_rdata;
   logic [1:0]                      s_axi_rresp;
   logic                            s_axi_rvalid;
   logic                            s_axi_rready;

   modport master (
      output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );

   modport slave (
      input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
             s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
             s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
   );
endinterface

// File: rtl/axilite_peripheral_regfile.sv
// AXI-Lite slave register bank terminating write, read and write-response traffic.
// NUM_REGS full-width registers, byte-strobe writes, DECERR on out-of-range addresses,
// independent write (WIdle/WResp) and read (RIdle/RData) handshake FSMs.
//
// Ports:
//   clk    clock
//   rst    synchronous active-high reset
//   s_axi  AXI-Lite slave modport (AW, W, B, AR, R channels)
module axilite_peripheral_regfile #(
   parameter int AXILITE_ADDR_WIDTH = 64,
   parameter int AXILITE_DATA_WIDTH = 512,
   parameter int NUM_REGS           = 8
) (
   input logic                         clk,
   input logic                         rst,
   axilite_peripheral_regfile_if.slave s_axi
);
   localparam int STRB_W = AXILITE_DATA_WIDTH / 8;
   localparam int OFS    = $clog2(STRB_W);
   localparam int IW     = $clog2(NUM_REGS);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [0:0] {WIdle, WResp} wr_state_e;
   typedef enum logic [0:0] {RIdle, RData} rd_state_e;

   logic [AXILITE_DATA_WIDTH-1:0] r_regs [NUM_REGS];

   // Write path state
   wr_state_e                     r_wr_state, w_wr_state_next;
   logic                          r_aw_done, r_w_done;
   logic [AXILITE_ADDR_WIDTH-1:0] r_awaddr;
   logic [AXILITE_DATA_WIDTH-1:0] r_wdata;
   logic [STRB_W-1:0]             r_wstrb;
   logic [1:0]                    r_bresp;

   // Read path state
   rd_state_e                     r_rd_state, w_rd_state_next;
   logic [AXILITE_DATA_WIDTH-1:0] r_rdata;
   logic [1:0]                    r_rresp;

   logic                          w_awready, w_wready, w_arready;
   logic                          w_aw_hs, w_w_hs, w_ar_hs;
   logic                          w_have_aw, w_have_w, w_commit;
   logic [AXILITE_ADDR_WIDTH-1:0] w_wr_addr, w_rd_addr;
   logic [AXILITE_DATA_WIDTH-1:0] w_wr_data;
   logic [STRB_W-1:0]             w_wr_strb;
   logic [IW-1:0]                 w_wr_idx, w_rd_idx;
   logic                          w_wr_err, w_rd_err;
   logic                          w_unused_addr_lsbs;

   // Readies depend only on registered state, never on valid.
   assign w_awready = (r_wr_state == WIdle) && !r_aw_done;
   assign w_wready  = (r_wr_state == WIdle) && !r_w_done;
   assign w_arready = (r_rd_state == RIdle);

   assign w_aw_hs = s_axi.s_axi_awvalid && w_awready;
   assign w_w_hs  = s_axi.s_axi_wvalid && w_wready;
   assign w_ar_hs = s_axi.s_axi_arvalid && w_arready;

   // A channel captured on an earlier edge comes from its holding register;
   // one handshaking this edge is used straight from the bus.
   assign w_have_aw = r_aw_done || w_aw_hs;
   assign w_have_w  = r_w_done || w_w_hs;
   assign w_wr_addr = r_aw_done ? r_awaddr : s_axi.s_axi_awaddr;
   assign w_wr_data = r_w_done ? r_wdata : s_axi.s_axi_wdata;
   assign w_wr_strb = r_w_done ? r_wstrb : s_axi.s_axi_wstrb;
   assign w_rd_addr = s_axi.s_axi_araddr;

   assign w_wr_idx = w_wr_addr[OFS +: IW];
   assign w_rd_idx = w_rd_addr[OFS +: IW];
   assign w_wr_err = |w_wr_addr[AXILITE_ADDR_WIDTH-1:OFS+IW];
   assign w_rd_err = |w_rd_addr[AXILITE_ADDR_WIDTH-1:OFS+IW];

   // Byte-offset bits are intentionally ignored.
   assign w_unused_addr_lsbs = ^{w_wr_addr[OFS-1:0], w_rd_addr[OFS-1:0]};

   // Write FSM
   always_ff @(posedge clk) begin
      if (rst) r_wr_state <= WIdle;
      else     r_wr_state <= w_wr_state_next;
   end

   always_comb begin
      w_wr_state_next = r_wr_state;
      w_commit        = 1'b0;
      case (r_wr_state)
         WIdle: begin
            if (w_have_aw && w_have_w) begin
               w_commit        = 1'b1;
               w_wr_state_next = WResp;
            end
         end
         WResp: begin
            if (s_axi.s_axi_bready) w_wr_state_next = WIdle;
         end
         default: w_wr_state_next = WIdle;
      endcase
   end

   // Read FSM
   always_ff @(posedge clk) begin
      if (rst) r_rd_state <= RIdle;
      else     r_rd_state <= w_rd_state_next;
   end

   always_comb begin
      w_rd_state_next = r_rd_state;
      case (r_rd_state)
         RIdle:   if (w_ar_hs) w_rd_state_next = RData;
         RData:   if (s_axi.s_axi_rready) w_rd_state_next = RIdle;
         default: w_rd_state_next = RIdle;
      endcase
   end

   // Write capture and register commit
   always_ff @(posedge clk) begin
      if (rst) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_awaddr  <= '0;
         r_wdata   <= '0;
         r_wstrb   <= '0;
         r_bresp   <= RESP_OKAY;
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else if (w_commit) begin
         r_aw_done <= 1'b0;
         r_w_done  <= 1'b0;
         r_bresp   <= w_wr_err ? RESP_DECERR : RESP_OKAY;
         if (!w_wr_err) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (w_wr_strb[b]) r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
            end
         end
      end else begin
         if (w_aw_hs) begin
            r_aw_done <= 1'b1;
            r_awaddr  <= s_axi.s_axi_awaddr;
         end
         if (w_w_hs) begin
            r_w_done <= 1'b1;
            r_wdata  <= s_axi.s_axi_wdata;
            r_wstrb  <= s_axi.s_axi_wstrb;
         end
      end
   end

   // Read capture samples the pre-edge register value, so a same-edge commit is not seen.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
         r_rresp <= RESP_OKAY;
      end else if (w_ar_hs) begin
         r_rdata <= w_rd_err ? '0 : r_regs[w_rd_idx];
         r_rresp <= w_rd_err ? RESP_DECERR : RESP_OKAY;
      end
   end

   assign s_axi.s_axi_awready = w_awready;
   assign s_axi.s_axi_wready  = w_wready;
   assign s_axi.s_axi_bvalid  = (r_wr_state == WResp);
   assign s_axi.s_axi_bresp   = r_bresp;
   assign s_axi.s_axi_arready = w_arready;
   assign s_axi.s_axi_rvalid  = (r_rd_state == RData);
   assign s_axi.s_axi_rdata   = r_rdata;
   assign s_axi.s_axi_rresp   = r_rresp;
endmodule
